// File: rtl/cla_pkg.sv
// Shared types and the span generate/propagate helper for the pipelined CLA adder.
package cla_pkg;

  localparam int LA_MAX = 64;

  typedef logic [LA_MAX-1:0] la_vec_t;

  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  // Combined generate/propagate of the low n entries of g/p; flattens to a
  // two-level lookahead term per output once unrolled.
  function automatic gp_t span_gp(input la_vec_t g, input la_vec_t p, input int unsigned n);
    gp_t r;
    r.g = 1'b0;
    r.p = 1'b1;
    for (int unsigned i = 0; i < LA_MAX; i++) begin
      if (i < n) begin
        r.g = g[i] | (p[i] & r.g);
        r.p = p[i] & r.p;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/cla_group.sv
// GROUP-bit carry-lookahead block: sum bits plus group generate/propagate.
module cla_group
  import cla_pkg::*;
#(
  parameter int GROUP = 4
) (
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b_eff,
  input  logic             cin,
  output logic [GROUP-1:0] sum,
  output logic             g,
  output logic             p
);

  la_vec_t          gv;
  la_vec_t          pv;
  gp_t              grp;
  gp_t              span;
  logic [GROUP-1:0] c;

  // Group G/P do not depend on cin, so keep them apart from the carry logic.
  always_comb begin
    gv = '0;
    pv = '0;
    gv[GROUP-1:0] = a & b_eff;
    pv[GROUP-1:0] = a ^ b_eff;
    grp = span_gp(gv, pv, GROUP);
    g = grp.g;
    p = grp.p;
  end

  always_comb begin
    span = '0;
    c    = '0;
    for (int unsigned k = 0; k < GROUP; k++) begin
      span = span_gp(gv, pv, k);
      c[k] = span.g | (span.p & cin);
    end
    sum = pv[GROUP-1:0] ^ c;
  end

endmodule

// File: rtl/pipelined_cla_adder.sv
// Elastic pipelined carry-lookahead adder/subtractor with valid/ready handshake.
// Define CLA_STATUS_EN to add the registered ovf and zero status outputs.
module pipelined_cla_adder
  import cla_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int GROUP  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef CLA_STATUS_EN
  ,
  output logic             ovf,
  output logic             zero
`endif
);

  localparam int NG = WIDTH / GROUP;
  localparam int K  = NG / STAGES;
  localparam int SW = K * GROUP;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c;
    logic             vld;
  } stage_t;

  stage_t            st_p [STAGES];
  logic [STAGES-1:0] ld;

`ifdef CLA_STATUS_EN
  logic ovf_p;
  logic zero_p;
  assign ovf  = ovf_p;
  assign zero = zero_p;
`endif

  // Load chain runs from the output back to the input: a stage may take a new
  // beat if it is empty or its successor is taking its current one.
  always_comb begin
    ld = '0;
    ld[STAGES-1] = !st_p[STAGES-1].vld || out_ready;
    for (int s = STAGES - 2; s >= 0; s--) begin
      ld[s] = !st_p[s].vld || ld[s+1];
    end
  end

  assign in_ready  = ld[0];
  assign out_valid = st_p[STAGES-1].vld;
  assign sum       = st_p[STAGES-1].sum;
  assign cout      = st_p[STAGES-1].c;

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    stage_t      sin;
    stage_t      snx;
    logic [K-1:0] grp_g;
    logic [K-1:0] grp_p;
    logic [K:0]   gc;
    logic [SW-1:0] ssum;
    la_vec_t     gv;
    la_vec_t     pv;
    gp_t         span;

    if (s == 0) begin : g_first
      always_comb begin
        sin     = '0;
        sin.a   = a;
        sin.b   = sub ? ~b : b;
        sin.c   = sub | cin;
        sin.vld = in_valid;
      end
    end else begin : g_next
      assign sin = st_p[s-1];
    end

    for (genvar k = 0; k < K; k++) begin : g_grp
      cla_group #(.GROUP(GROUP)) u_grp (
        .a     (sin.a[s*SW + k*GROUP +: GROUP]),
        .b_eff (sin.b[s*SW + k*GROUP +: GROUP]),
        .cin   (gc[k]),
        .sum   (ssum[k*GROUP +: GROUP]),
        .g     (grp_g[k]),
        .p     (grp_p[k])
      );
    end

    // Second-level lookahead: every group carry is formed directly from the
    // stage carry-in, so nothing ripples between groups of a stage.
    always_comb begin
      gv   = '0;
      pv   = '0;
      span = '0;
      gv[K-1:0] = grp_g;
      pv[K-1:0] = grp_p;
      gc[0] = sin.c;
      for (int unsigned k = 0; k < K; k++) begin
        span    = span_gp(gv, pv, k + 1);
        gc[k+1] = span.g | (span.p & sin.c);
      end
    end

    always_comb begin
      snx = sin;
      snx.sum[s*SW +: SW] = ssum;
      snx.c = gc[K];
    end

    // ---- stage s register boundary ----
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        st_p[s] <= '0;
      end else if (ld[s]) begin
        st_p[s] <= snx;
      end
    end

`ifdef CLA_STATUS_EN
    if (s == STAGES - 1) begin : g_status
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_p  <= 1'b0;
          zero_p <= 1'b0;
        end else if (ld[s]) begin
          zero_p <= (snx.sum == '0);
          ovf_p  <= (snx.a[WIDTH-1] == snx.b[WIDTH-1]) && (snx.sum[WIDTH-1] != snx.a[WIDTH-1]);
        end
      end
    end
`endif
  end

endmodule
